// File: rtl/ibex_efpga_multi_if_if.sv
// Bundle of the EX-stage request/response signals and the eFPGA fabric strobe/done/result lines.
// The controller connects to the slave modport; the EX stage and fabric side use master.
interface ibex_efpga_multi_if_if #(
    parameter int NumResults  = 3,
    parameter int ResultWidth = 32,
    parameter int OpWidth     = 2,
    parameter int DelayWidth  = 4
);
    logic                              en_i;
    logic [OpWidth-1:0]                operator_i;
    logic [DelayWidth-1:0]             delay_i;
    logic [NumResults*ResultWidth-1:0] result_i;
    logic                              efpga_done_i;
    logic                              write_strobe_o;
    logic                              ready_o;
    logic [ResultWidth-1:0]            result_o;
    logic                              timeout_o;
    logic                              busy_o;

    modport slave (
        input  en_i, operator_i, delay_i, result_i, efpga_done_i,
        output write_strobe_o, ready_o, result_o, timeout_o, busy_o
    );

    modport master (
        output en_i, operator_i, delay_i, result_i, efpga_done_i,
        input  write_strobe_o, ready_o, result_o, timeout_o, busy_o
    );
endinterface

// File: rtl/ibex_efpga_multi_if.sv
// EX-stage controller for custom instructions executed in the eFPGA fabric: strobes the fabric,
// waits a fixed latency or for the done handshake (with timeout), then returns the selected result.
//
// state  | meaning
// IDLE   | no op in flight; en_i starts one
// STROBE | one-cycle write strobe to the fabric
// WAIT   | counting down the fixed latency or waiting for efpga_done_i
// DONE   | one-cycle ready pulse with result/timeout valid
module ibex_efpga_multi_if #(
    parameter int NumResults    = 3,
    parameter int ResultWidth   = 32,
    parameter int OpWidth       = 2,
    parameter int DelayWidth    = 4,
    parameter int TimeoutCycles = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    ibex_efpga_multi_if_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, STROBE, WAIT, DONE} state_e;

    localparam int MaxDelay = (1 << DelayWidth) - 1;
    localparam int MaxCnt   = (MaxDelay > TimeoutCycles) ? MaxDelay : TimeoutCycles;
    localparam int CntWidth = $clog2(MaxCnt + 1);

    state_e                 state_q, state_d;
    logic [CntWidth-1:0]    cnt_q, cnt_d;
    logic [OpWidth-1:0]     op_q, op_d;
    logic                   hs_q, hs_d;
    logic [ResultWidth-1:0] result_q, result_d;
    logic                   timeout_q, timeout_d;
    logic [ResultWidth-1:0] sel_result;

    // Out-of-range operators fall through to zero rather than indexing past result_i.
    always_comb begin
        sel_result = '0;
        for (int k = 0; k < NumResults; k++) begin
            if (int'(op_q) == k) begin
                sel_result = bus.result_i[k*ResultWidth +: ResultWidth];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            hs_q      <= 1'b0;
            result_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            hs_q      <= hs_d;
            result_q  <= result_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        hs_d      = hs_q;
        result_d  = result_q;
        timeout_d = timeout_q;
        case (state_q)
            IDLE: begin
                if (bus.en_i) begin
                    state_d   = STROBE;
                    op_d      = bus.operator_i;
                    hs_d      = (bus.delay_i == '0);
                    cnt_d     = (bus.delay_i == '0) ? CntWidth'(TimeoutCycles)
                                                    : CntWidth'(bus.delay_i);
                    timeout_d = 1'b0;
                end
            end
            STROBE: begin
                state_d = bus.en_i ? WAIT : IDLE;
            end
            WAIT: begin
                if (!bus.en_i) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    // Done takes priority over a timeout expiring in the same cycle.
                    if (hs_q && bus.efpga_done_i) begin
                        result_d = sel_result;
                        state_d  = DONE;
                    end else if (cnt_q == CntWidth'(1)) begin
                        result_d  = hs_q ? '0 : sel_result;
                        timeout_d = hs_q;
                        state_d   = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.write_strobe_o = (state_q == STROBE);
    assign bus.ready_o        = (state_q == DONE);
    assign bus.busy_o         = (state_q != IDLE);
    assign bus.result_o       = result_q;
    assign bus.timeout_o      = timeout_q;
endmodule

// File: tb/tb_ibex_efpga_multi_if.sv
// Scoreboard bench for ibex_efpga_multi_if: the driver predicts each op's completion from the
// timing rules and queues it; a separate monitor matches every strobe/ready pulse against the queues.
module tb_ibex_efpga_multi_if;
    localparam int T = 8;

    typedef struct {
        int          cyc;
        logic [31:0] res;
        bit          to;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    logic [31:0] last_res = '0;
    exp_t exp_q[$];
    int   strobe_q[$];

    ibex_efpga_multi_if_if #(.NumResults(3), .ResultWidth(32), .OpWidth(2), .DelayWidth(4)) bus ();

    ibex_efpga_multi_if #(
        .NumResults(3), .ResultWidth(32), .OpWidth(2), .DelayWidth(4), .TimeoutCycles(T)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference: when does the op end, with what result and timeout flag.
    function automatic exp_t model(input int s, input int d, input int op,
                                   input logic [95:0] chs, input int done_rel);
        exp_t e;
        logic [31:0] chv;
        chv = (op < 3) ? chs[op*32 +: 32] : 32'h0;
        if (d > 0) begin
            e.cyc = s + d + 2; e.res = chv; e.to = 1'b0;
        end else if (done_rel >= 2 && done_rel <= T + 1) begin
            e.cyc = s + done_rel + 1; e.res = chv; e.to = 1'b0;
        end else begin
            e.cyc = s + T + 2; e.res = 32'h0; e.to = 1'b1;
        end
        return e;
    endfunction

    task automatic run_op(input int d, input int op, input int done_rel, input bit spurious,
                          input logic [95:0] chs);
        int   s;
        exp_t e;
        @(negedge clk);
        bus.en_i         = 1'b1;
        bus.delay_i      = 4'(d);
        bus.operator_i   = 2'(op);
        bus.result_i     = chs;
        bus.efpga_done_i = 1'b0;
        s = cyc;
        e = model(s, d, op, chs, done_rel);
        exp_q.push_back(e);
        strobe_q.push_back(s + 1);
        for (int rel = 1; rel <= e.cyc - s; rel++) begin
            @(negedge clk);
            bus.operator_i = 2'($urandom);
            bus.delay_i    = 4'($urandom);
            if (d > 0) bus.efpga_done_i = spurious ? 1'($urandom) : 1'b0;
            else       bus.efpga_done_i = (rel == done_rel) || (spurious && rel == 1);
            if (rel == e.cyc - s) bus.efpga_done_i = 1'b0;
        end
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.en_i         = 1'b0;
            bus.efpga_done_i = 1'b0;
        end
    endtask

    task automatic run_abort(input int d, input int op, input int abort_rel);
        int s;
        @(negedge clk);
        bus.en_i         = 1'b1;
        bus.delay_i      = 4'(d);
        bus.operator_i   = 2'(op);
        bus.efpga_done_i = 1'b0;
        s = cyc;
        strobe_q.push_back(s + 1);
        for (int rel = 1; rel <= abort_rel; rel++) begin
            @(negedge clk);
            if (rel == abort_rel) bus.en_i = 1'b0;
        end
        @(negedge clk);
        check("abort_busy", 64'(bus.busy_o), 64'(0));
        check("abort_result_held", 64'(bus.result_o), 64'(last_res));
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, "_strobe"},  64'(bus.write_strobe_o), 64'(0));
        check({nm, "_ready"},   64'(bus.ready_o),        64'(0));
        check({nm, "_timeout"}, 64'(bus.timeout_o),      64'(0));
        check({nm, "_busy"},    64'(bus.busy_o),         64'(0));
        check({nm, "_result"},  64'(bus.result_o),       64'(0));
    endtask

    // Monitor: consumes predicted strobes and completions as the DUT presents them.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.write_strobe_o) begin
                if (strobe_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_strobe: actual=1 at cycle %0d required=none", cyc);
                end else begin
                    check("strobe_cycle", 64'(strobe_q.pop_front()), 64'(cyc));
                    check("timeout_cleared_at_start", 64'(bus.timeout_o), 64'(0));
                end
            end
            if (bus.ready_o) begin
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_ready: actual=1 at cycle %0d required=none", cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("ready_cycle", 64'(cyc), 64'(e.cyc));
                    check("result", 64'(bus.result_o), 64'(e.res));
                    check("timeout", 64'(bus.timeout_o), 64'(e.to));
                    last_res = e.res;
                end
            end
        end
    end

    initial begin
        repeat (50000) @(posedge clk);
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.en_i = 1'b0; bus.operator_i = '0; bus.delay_i = '0;
        bus.result_i = '0; bus.efpga_done_i = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        run_op(3, 1, -1, 1'b1, {32'h11111111, 32'hDEADBEEF, 32'h22222222});
        gap(2);
        run_op(0, 2, 6, 1'b1, {32'h12345678, 32'h33333333, 32'h44444444});
        gap(2);
        run_op(0, 1, -1, 1'b0, {32'h55555555, 32'h66666666, 32'h77777777});
        gap(1);
        run_op(0, 0, T + 1, 1'b0, {32'h0, 32'h0, 32'hCAFEF00D});
        gap(1);
        run_op(1, 3, -1, 1'b0, {32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC});
        gap(1);
        run_op(1, 0, -1, 1'b1, {32'h0, 32'h0, 32'h01020304});
        run_op(1, 2, -1, 1'b1, {32'h0A0B0C0D, 32'h0, 32'h0});
        gap(1);
        run_abort(5, 1, 2);
        gap(1);

        // Reset during the WAIT phase of a fixed-latency op.
        run_op(2, 0, -1, 1'b0, {32'h0, 32'h0, 32'h89ABCDEF});
        @(negedge clk);
        bus.en_i = 1'b1; bus.delay_i = 4'd5; bus.operator_i = 2'd0;
        strobe_q.push_back(cyc + 1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("reset_mid_op");
        bus.en_i = 1'b0;
        last_res = '0;
        @(negedge clk);
        rst_n = 1'b1;
        gap(3);

        for (int i = 0; i < 40; i++) begin
            int d, op, dr;
            d  = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 15);
            op = $urandom_range(0, 3);
            dr = ($urandom_range(0, 3) == 0) ? -1 : $urandom_range(2, T + 3);
            if ($urandom_range(0, 4) == 0) begin
                run_abort(d, op, $urandom_range(1, (d > 0) ? d + 1 : T + 1));
                gap($urandom_range(0, 2));
            end else begin
                run_op(d, op, dr, 1'($urandom), {$urandom, $urandom, $urandom});
                if ($urandom_range(0, 1) == 0) gap($urandom_range(1, 3));
            end
        end
        gap(6);
        check("pending_ready", 64'(exp_q.size()), 64'(0));
        check("pending_strobe", 64'(strobe_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
